// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite bus arbiter with lock, burst protection and tenure limit.
// Grant updates at the edge ending a rearbitration cycle; HREADY=0 freezes all state.
module ahb_bus_arbiter #(
    parameter int NUM_MST    = 3,
    parameter int DEF_MST    = 0,
    parameter int MAX_TENURE = 16,
    parameter int IDX_W      = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [NUM_MST-1:0] REQ,
    input  logic [NUM_MST-1:0] LOCK,
    input  logic [1:0]         HTRANS,
    input  logic               HREADY,
    output logic [NUM_MST-1:0] GRANT,
    output logic [IDX_W-1:0]   HMASTER,
    output logic               HMASTLOCK,
    output logic [IDX_W-1:0]   HMASTER_DATA
);

    typedef enum logic [1:0] {
        ST_DEFAULT = 2'd0,
        ST_OWNED   = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [1:0]         TR_IDLE   = 2'b00;
    localparam logic [1:0]         TR_NONSEQ = 2'b10;
    localparam logic [IDX_W-1:0]   DEF_IDX   = IDX_W'(DEF_MST);
    localparam logic [7:0]         MAX_TEN   = 8'(MAX_TENURE);
    localparam logic [NUM_MST-1:0] ONE_HOT0  = {{(NUM_MST-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     owner_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [7:0]           ten_q, ten_d;
    logic [NUM_MST-1:0]   grant_d;
    logic                 rp;
    logic                 xfer;
    logic                 own_req;
    logic                 own_lock;
    logic                 others;
    logic                 win_vld;
    logic [IDX_W-1:0]     win_idx;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % NUM_MST;
        return IDX_W'(s);
    endfunction

    assign rp       = HREADY && (HTRANS == TR_IDLE || HTRANS == TR_NONSEQ);
    assign xfer     = HTRANS[1];
    assign own_req  = REQ[HMASTER];
    assign own_lock = REQ[HMASTER] & LOCK[HMASTER];
    assign others   = |(REQ & ~GRANT);

    // Search starts just after the last winner, so the current owner is considered last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 1; i <= NUM_MST; i++) begin
            if (!win_vld && REQ[rr_idx(rr_q, i)]) begin
                win_vld = 1'b1;
                win_idx = rr_idx(rr_q, i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = HMASTER;
        rr_d    = rr_q;
        ten_d   = ten_q;
        if (state_q != ST_DEFAULT && xfer && ten_q < MAX_TEN) begin
            ten_d = ten_q + 8'd1;
        end
        if (rp) begin
            unique case (state_q)
                ST_DEFAULT: begin
                    if (win_vld) begin
                        owner_d = win_idx;
                        rr_d    = win_idx;
                        ten_d   = 8'd0;
                        state_d = LOCK[win_idx] ? ST_LOCKED : ST_OWNED;
                    end
                end
                default: begin
                    if (state_q == ST_LOCKED && own_lock) begin
                        state_d = ST_LOCKED;
                    end else if (!own_req) begin
                        ten_d = 8'd0;
                        if (win_vld) begin
                            owner_d = win_idx;
                            rr_d    = win_idx;
                            state_d = LOCK[win_idx] ? ST_LOCKED : ST_OWNED;
                        end else begin
                            owner_d = DEF_IDX;
                            state_d = ST_DEFAULT;
                        end
                    end else if (others && ten_q >= MAX_TEN) begin
                        owner_d = win_idx;
                        rr_d    = win_idx;
                        ten_d   = 8'd0;
                        state_d = LOCK[win_idx] ? ST_LOCKED : ST_OWNED;
                    end else begin
                        state_d = own_lock ? ST_LOCKED : ST_OWNED;
                    end
                end
            endcase
        end
        grant_d = ONE_HOT0 << owner_d;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_DEFAULT;
            HMASTER      <= DEF_IDX;
            HMASTER_DATA <= DEF_IDX;
            GRANT        <= ONE_HOT0 << DEF_IDX;
            rr_q         <= DEF_IDX;
            ten_q        <= 8'd0;
        end else if (HREADY) begin
            state_q      <= state_d;
            HMASTER      <= owner_d;
            HMASTER_DATA <= HMASTER;
            GRANT        <= grant_d;
            rr_q         <= rr_d;
            ten_q        <= ten_d;
        end
    end

    assign HMASTLOCK = (state_q == ST_LOCKED);

endmodule
